hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage (F, D, E, M, W) 16-bit RISC core. It tracks in-flight register writes in a three-entry scoreboard mirroring the E, M and W stages. It also:
- stalls fetch/decode on load-use hazards;
- inserts bubbles into the ID/EX register;
- produces registered forwarding selects for the execute-stage ALU operands.

It sits beside `decode_stage` and consumes the decoded register addresses and control bits.

## Interface
Parameters:
- `REG_AW`, default 3: register address width (8 registers, r0 is an ordinary register).
- `CNT_W`, default 16: stall performance-counter width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `id_valid`, in, 1: decode holds a valid instruction.
- `id_src1`, `id_src2`, in, REG_AW: source register addresses.
- `id_use_src1`, `id_use_src2`, in, 1: the instruction actually reads that source.
- `id_dst`, in, REG_AW: destination register address.
- `id_reg_write`, in, 1: the instruction writes `id_dst`.
- `id_mem_read`, in, 1: the instruction is a load.
- `flush`, in, 1: taken branch resolved in E; squash the F and D instructions.
- `mem_busy`, in, 1: data memory not ready; freeze the whole pipeline.
- `stall_fd`, out, 1: hold PC and the IF/ID register.
- `bubble_ex`, out, 1: load a NOP into the ID/EX register.
- `fwd_a`, `fwd_b`, out, 2: E-stage operand select. 00 = reg file, 01 = EX/MEM, 10 = MEM/WB, 11 = reserved, never driven.
- `stall_cnt`, out, CNT_W: saturating count of load-use stall cycles.

## Operation
Scoreboard:
- Three entries `sb_e`, `sb_m`, `sb_w`, each holding {valid, dst, is_load}. Only instructions with `reg_write` = 1 make an entry valid.
- Normal advance, per cycle: `sb_w` ← `sb_m`, `sb_m` ← `sb_e`, `sb_e` ← decode entry.
- The decode entry is valid only when `id_valid` & `id_reg_write` & !`bubble_ex`.
- An operand "matches" an entry when the entry is valid, `id_use_srcN` = 1 and `id_srcN` == entry `dst`.

Load-use hazard:
- Condition: a used source matches `sb_e` with `is_load` = 1.
- Response: `stall_fd` = 1 and `bubble_ex` = 1 for one cycle.

Forward select for each operand, registered into `fwd_a`/`fwd_b` when decode advances:
- Match on `sb_e` (and not a load) → 01.
- Else match on `sb_m` → 10. This covers a load after its one stall.
- Else → 00.
- `sb_e` takes priority over `sb_m` (youngest producer wins).
- `sb_w` matches need no forwarding: the reg file has write-before-read bypass.

Priority, highest first:
1. `rst` low: `stall_fd`, `bubble_ex`, `fwd_a`, `fwd_b` and `stall_cnt` are forced to 0, and the scoreboard is invalidated.
2. `mem_busy`: scoreboard, `fwd_a`/`fwd_b` and `stall_cnt` hold; `stall_fd` = 1, `bubble_ex` = 0.
3. `flush`: `bubble_ex` = 1, `stall_fd` = 0, the decode entry is discarded, and `fwd_*` ← 00. The scoreboard still advances, so the branch's own entry moves to M.
4. Load-use: as above; `fwd_*` ← 00 with the bubble; `stall_cnt` += 1, saturating at all-ones.
5. Normal advance.

Invalid decode (`id_valid` = 0): no hazard is evaluated, a bubble enters E, and `fwd_*` ← 00.

## Timing
- `stall_fd` and `bubble_ex` are combinational from current scoreboard state plus `id_*`, `flush` and `mem_busy`, within the same cycle.
- `fwd_a`/`fwd_b` are registered with 1-cycle latency and are valid during the cycle the consuming instruction occupies E.
- A load-use stall lasts exactly one cycle. A dependent instruction after the stall sees `fwd` = 10.
- `mem_busy` during a load-use stall: the stall persists, and the bubble is inserted only on the first non-busy edge.
- Reset deassertion: the first edge after it performs a normal advance from the empty scoreboard.

## Structure
- The shared `pipeline_pkg` (or header) holds:
  - the `FWD_RF`/`FWD_EXMEM`/`FWD_MEMWB` encodings;
  - `REG_AW`;
  - the scoreboard entry layout {valid, dst, is_load}, also used by the decode and execute stages.
- Sub-module `hazard_sb_stage`: one scoreboard entry register with load/hold/clear controls, instantiated three times.
- Hazard/forward comparators and the priority logic live in the top module.

## Test plan
- ALU dependency: `add r1` then `sub r2,r1,r3` back-to-back → no stall; `fwd_a` = 01 in the sub's E cycle.
- Load-use: `ld r4` then `add r5,r4,r4` → `stall_fd`/`bubble_ex` = 1 for one cycle, then `fwd_a` = `fwd_b` = 10, and `stall_cnt` = 1.
- Distance-2 dependency: `add r1`, independent instruction, `or r6,r1` → `fwd_a` = 10. At distance 3 → 00.
- Flush: `flush` = 1 while decode holds `ld`-dependent `add r5,r4` → `bubble_ex` = 1, `stall_fd` = 0, no counter increment, and the next E cycle has `fwd` = 00.
- `mem_busy` for 3 cycles during a load-use stall → `stall_fd` high for 4 cycles, one bubble, scoreboard unchanged until release.
- Async reset mid-stall: all outputs go to 0 immediately, with no clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, register address width
// and the scoreboard entry layout used by the decode, execute and hazard logic.
package pipeline_pkg;

    localparam int REG_AW = 3;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              is_load;
    } sb_entry_t;

    // Youngest producer wins; a W-stage producer is covered by the register
    // file's write-before-read bypass, so it still selects the register file.
    function automatic logic [1:0] fwd_select(input logic hit_e, input logic hit_m,
                                              input logic hit_w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (hit_e) begin
            sel = FWD_EXMEM;
        end else if (hit_m) begin
            sel = FWD_MEMWB;
        end else if (hit_w) begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One scoreboard entry register {valid, dst, is_load}; clear beats load, otherwise hold.
module hazard_sb_stage #(
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_dst,
    input  logic              d_is_load,
    output logic              q_valid,
    output logic [REG_AW-1:0] q_dst,
    output logic              q_is_load
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid   <= 1'b0;
            q_dst     <= '0;
            q_is_load <= 1'b0;
        end else if (clear) begin
            q_valid   <= 1'b0;
            q_is_load <= 1'b0;
        end else if (load) begin
            q_valid   <= d_valid;
            q_dst     <= d_dst;
            q_is_load <= d_is_load;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall / bubble control and registered E-stage forwarding selects,
// driven by a three-entry scoreboard that mirrors the E, M and W stages.
module hazard_unit #(
    parameter int REG_AW = pipeline_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use_src1,
    input  logic              id_use_src2,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              stall_fd,
    output logic              bubble_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              e_valid, m_valid, w_valid;
    logic [REG_AW-1:0] e_dst, m_dst, w_dst;
    logic              e_is_load, m_is_load, w_load_unused;

    logic hit_e_a, hit_m_a, hit_w_a;
    logic hit_e_b, hit_m_b, hit_w_b;
    logic load_use, advance, squash, bubble_int, dec_valid;
    logic [1:0] fwd_a_next, fwd_b_next;

    always_comb begin
        hit_e_a = e_valid & id_use_src1 & (id_src1 == e_dst);
        hit_m_a = m_valid & id_use_src1 & (id_src1 == m_dst);
        hit_w_a = w_valid & id_use_src1 & (id_src1 == w_dst);
        hit_e_b = e_valid & id_use_src2 & (id_src2 == e_dst);
        hit_m_b = m_valid & id_use_src2 & (id_src2 == m_dst);
        hit_w_b = w_valid & id_use_src2 & (id_src2 == w_dst);

        load_use   = id_valid & e_is_load & (hit_e_a | hit_e_b);
        advance    = !mem_busy;
        bubble_int = advance & (flush | load_use);
        // No real instruction enters E this edge, so E must read the register file.
        squash     = flush | load_use | !id_valid;
        dec_valid  = id_valid & id_reg_write & !bubble_int;

        fwd_a_next = squash ? pipeline_pkg::FWD_RF
                            : pipeline_pkg::fwd_select(hit_e_a, hit_m_a, hit_w_a);
        fwd_b_next = squash ? pipeline_pkg::FWD_RF
                            : pipeline_pkg::fwd_select(hit_e_b, hit_m_b, hit_w_b);

        // Reset forces the combinational controls low without waiting for a clock.
        stall_fd  = rst & (mem_busy | (load_use & !flush));
        bubble_ex = rst & bubble_int;
    end

    hazard_sb_stage #(.REG_AW(REG_AW)) u_sb_e (
        .clk       (clk),
        .rst       (rst),
        .load      (advance & dec_valid),
        .clear     (advance & !dec_valid),
        .d_valid   (dec_valid),
        .d_dst     (id_dst),
        .d_is_load (id_mem_read),
        .q_valid   (e_valid),
        .q_dst     (e_dst),
        .q_is_load (e_is_load)
    );

    hazard_sb_stage #(.REG_AW(REG_AW)) u_sb_m (
        .clk       (clk),
        .rst       (rst),
        .load      (advance),
        .clear     (1'b0),
        .d_valid   (e_valid),
        .d_dst     (e_dst),
        .d_is_load (e_is_load),
        .q_valid   (m_valid),
        .q_dst     (m_dst),
        .q_is_load (m_is_load)
    );

    // W-stage load flag has no consumer: those results are already in the register file.
    hazard_sb_stage #(.REG_AW(REG_AW)) u_sb_w (
        .clk       (clk),
        .rst       (rst),
        .load      (advance),
        .clear     (1'b0),
        .d_valid   (m_valid),
        .d_dst     (m_dst),
        .d_is_load (m_is_load),
        .q_valid   (w_valid),
        .q_dst     (w_dst),
        .q_is_load (w_load_unused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a     <= pipeline_pkg::FWD_RF;
            fwd_b     <= pipeline_pkg::FWD_RF;
            stall_cnt <= '0;
        end else if (advance) begin
            fwd_a <= fwd_a_next;
            fwd_b <= fwd_b_next;
            if (load_use && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
